// File: rtl/regfile_pkg.sv
// Shared types and defaults for the scoreboarded register file.
// Holds the clear/run state encoding, default geometry and the hardwired-zero index.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_ZERO   = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write bit vector: issue sets, writeback clears, a same-cycle set wins; async reset.
// Busy lookup is combinational; with REGFILE_BYPASS_EN a same-cycle writeback masks busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     runMode,
    input  logic                     setEn,
    input  logic [ADDR_W-1:0]        setIdx,
    input  logic                     clrEn,
    input  logic [ADDR_W-1:0]        clrIdx,
    input  logic [NUM_RD*ADDR_W-1:0] lookupIdx,
    output logic [NUM_RD-1:0]        busy,
    output logic                     anyPending
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] nextPending;

    // Clear first, then set, so a newly issued producer keeps the register busy.
    always_comb begin
        nextPending = pending;
        if (clrEn) begin
            nextPending[clrIdx] = 1'b0;
        end
        if (setEn) begin
            nextPending[setIdx] = 1'b1;
        end
        nextPending[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= nextPending;
        end
    end

    assign anyPending = |pending;

    for (genvar i = 0; i < NUM_RD; i++) begin : gBusy
        logic [ADDR_W-1:0] idx;
        logic              wrHit;
        assign idx = lookupIdx[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        assign wrHit = clrEn && (clrIdx == idx);
`else
        assign wrHit = 1'b0;
`endif
        assign busy[i] = runMode && pending[idx] && !wrHit;
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with scoreboard; sequential array clear after reset (ready after DEPTH edges).
// Combinational reads, synchronous write; no handshake, traffic while !ready is dropped. Option: REGFILE_BYPASS_EN.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ready,
    input  logic [NUM_RD*ADDR_W-1:0] readRegister,
    output logic [NUM_RD*DATA_W-1:0] readData,
    output logic [NUM_RD-1:0]        readBusy,
    input  logic                     regWriteCtrl,
    input  logic [ADDR_W-1:0]        writeRegister,
    input  logic [DATA_W-1:0]        writeData,
    input  logic                     issueValid,
    input  logic [ADDR_W-1:0]        issueRegister,
    output logic                     anyPending
);

    localparam int DEPTH = 1 << ADDR_W;

    state_t            state;
    state_t            nextState;
    logic [ADDR_W-1:0] clearIdx;
    logic              runMode;
    logic              wrEn;
    logic              issEn;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            CLEAR:   if (clearIdx == '1) nextState = RUN;
            RUN:     nextState = RUN;
            default: nextState = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clearIdx <= '0;
        end else if (state == CLEAR) begin
            clearIdx <= clearIdx + 1'b1;
        end
    end

    assign runMode = (state == RUN);
    assign ready   = runMode;
    assign wrEn    = runMode && regWriteCtrl && (writeRegister != ADDR_W'(REG_ZERO));
    assign issEn   = runMode && issueValid && (issueRegister != ADDR_W'(REG_ZERO));

    // The array itself is not reset; the CLEAR sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clearIdx] <= '0;
        end else if (wrEn) begin
            mem[writeRegister] <= writeData;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : gRead
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] arrData;
        assign idx     = readRegister[i*ADDR_W +: ADDR_W];
        assign arrData = (idx == ADDR_W'(REG_ZERO)) ? '0 : mem[idx];
`ifdef REGFILE_BYPASS_EN
        assign readData[i*DATA_W +: DATA_W] =
            !runMode                             ? '0        :
            (wrEn && (writeRegister == idx))     ? writeData :
                                                   arrData;
`else
        assign readData[i*DATA_W +: DATA_W] = runMode ? arrData : '0;
`endif
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) uScoreboard (
        .clk        (clk),
        .rst        (rst),
        .runMode    (runMode),
        .setEn      (issEn),
        .setIdx     (issueRegister),
        .clrEn      (wrEn),
        .clrIdx     (writeRegister),
        .lookupIdx  (readRegister),
        .busy       (readBusy),
        .anyPending (anyPending)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (DATA_W=32, ADDR_W=5, NUM_RD=2); expectations follow REGFILE_BYPASS_EN.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [9:0]  readRegister;
    logic [63:0] readData;
    logic [1:0]  readBusy;
    logic        regWriteCtrl;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic        issueValid;
    logic [4:0]  issueRegister;
    logic        anyPending;

    int checks = 0;
    int errors = 0;
    int readyEdge;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .ready         (ready),
        .readRegister  (readRegister),
        .readData      (readData),
        .readBusy      (readBusy),
        .regWriteCtrl  (regWriteCtrl),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .issueValid    (issueValid),
        .issueRegister (issueRegister),
        .anyPending    (anyPending)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rdAddr(input logic [4:0] p0, input logic [4:0] p1);
        readRegister = {p1, p0};
        #1;
    endtask

    // Counts edges after release until ready is first seen high; 0 if it never rises.
    task automatic waitReady(output int edgeNum);
        edgeNum = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (ready && edgeNum == 0) edgeNum = k;
            if (edgeNum != 0) break;
        end
    endtask

    initial begin
        rst = 1'b1;
        readRegister = '0;
        regWriteCtrl = 1'b0;
        writeRegister = '0;
        writeData = '0;
        issueValid = 1'b0;
        issueRegister = '0;
        rdAddr(5'd3, 5'd4);
        repeat (2) step();
        chk("reset_ready", {63'd0, ready}, 64'd0);
        chk("reset_data", readData, 64'd0);
        chk("reset_busy", {62'd0, readBusy}, 64'd0);
        chk("reset_anyPending", {63'd0, anyPending}, 64'd0);

        rst = 1'b0;
        step();
        chk("clear_ready_low", {63'd0, ready}, 64'd0);
        // First edge already consumed; count the rest.
        waitReady(readyEdge);
        chk("clear_latency", 64'(readyEdge == 0 ? 0 : readyEdge + 1), 64'd32);

        for (int r = 0; r < 32; r++) begin
            rdAddr(5'(r), 5'(31 - r));
            chk($sformatf("zero_r%0d", r), readData, 64'd0);
        end
        chk("idle_anyPending", {63'd0, anyPending}, 64'd0);

        // Write r5 = all ones.
        rdAddr(5'd5, 5'd5);
        regWriteCtrl = 1'b1; writeRegister = 5'd5; writeData = 32'hFFFF_FFFF;
        #1;
        chk("r5_same_cycle", {32'd0, readData[31:0]}, BYP ? 64'hFFFF_FFFF : 64'd0);
        step();
        regWriteCtrl = 1'b0;
        #1;
        chk("r5_next_cycle", readData, 64'hFFFF_FFFF_FFFF_FFFF);

        // Write and issue r0: both dropped.
        rdAddr(5'd0, 5'd0);
        regWriteCtrl = 1'b1; writeRegister = 5'd0; writeData = 32'h1234;
        issueValid = 1'b1; issueRegister = 5'd0;
        #1;
        chk("r0_same_cycle", readData, 64'd0);
        step();
        regWriteCtrl = 1'b0; issueValid = 1'b0;
        #1;
        chk("r0_data", readData, 64'd0);
        chk("r0_busy", {62'd0, readBusy}, 64'd0);
        chk("r0_anyPending", {63'd0, anyPending}, 64'd0);

        // Issue r7.
        rdAddr(5'd5, 5'd7);
        issueValid = 1'b1; issueRegister = 5'd7;
        #1;
        chk("r7_busy_before", {62'd0, readBusy}, 64'd0);
        step();
        issueValid = 1'b0;
        #1;
        chk("r7_busy_issued", {62'd0, readBusy}, 64'b10);
        chk("r7_anyPending", {63'd0, anyPending}, 64'd1);

        // Write and re-issue r7 together: set wins.
        regWriteCtrl = 1'b1; writeRegister = 5'd7; writeData = 32'h77;
        issueValid = 1'b1; issueRegister = 5'd7;
        #1;
        chk("r7_busy_wr_same", {63'd0, readBusy[1]}, BYP ? 64'd0 : 64'd1);
        chk("r7_data_wr_same", {32'd0, readData[63:32]}, BYP ? 64'h77 : 64'd0);
        step();
        regWriteCtrl = 1'b0; issueValid = 1'b0;
        #1;
        chk("r7_still_pending", {62'd0, readBusy}, 64'b10);
        chk("r7_anyPending_kept", {63'd0, anyPending}, 64'd1);
        chk("r7_data_77", {32'd0, readData[63:32]}, 64'h77);

        // Write r7 only: pending clears.
        regWriteCtrl = 1'b1; writeRegister = 5'd7; writeData = 32'h88;
        step();
        regWriteCtrl = 1'b0;
        #1;
        chk("r7_busy_cleared", {62'd0, readBusy}, 64'd0);
        chk("r7_anyPending_cleared", {63'd0, anyPending}, 64'd0);
        chk("r7_data_88", {32'd0, readData[63:32]}, 64'h88);

        // Same-port aliasing.
        rdAddr(5'd7, 5'd7);
        chk("alias_data", readData, 64'h0000_0088_0000_0088);

        // Pend r3, then reset asynchronously in RUN.
        rdAddr(5'd3, 5'd5);
        issueValid = 1'b1; issueRegister = 5'd3;
        step();
        issueValid = 1'b0;
        #1;
        chk("r3_pending", {62'd0, readBusy}, 64'b01);
        rst = 1'b1;
        #1;
        chk("rst_pending_cleared", {63'd0, anyPending}, 64'd0);
        chk("rst_ready_low", {63'd0, ready}, 64'd0);
        step();
        rst = 1'b0;
        // Ten clear edges, then reset again at clearIdx=10.
        repeat (10) step();
        chk("clear_mid_ready_low", {63'd0, ready}, 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        // Requests during CLEAR must be ignored.
        regWriteCtrl = 1'b1; writeRegister = 5'd9; writeData = 32'hAB;
        issueValid = 1'b1; issueRegister = 5'd9;
        waitReady(readyEdge);
        regWriteCtrl = 1'b0; issueValid = 1'b0;
        #1;
        chk("restart_latency", 64'(readyEdge), 64'd32);
        rdAddr(5'd9, 5'd5);
        chk("r9_r5_cleared", readData, 64'd0);
        chk("r9_not_busy", {62'd0, readBusy}, 64'd0);
        chk("restart_anyPending", {63'd0, anyPending}, 64'd0);
        rdAddr(5'd7, 5'd3);
        chk("r7_r3_cleared", readData, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
